// File: rtl/softmax_online_p.sv
// softmax_online_p: per-lane online-softmax statistics unit.
// Streams a row of TILES beats per lane, tracking the running integer max and
// a power-of-two exponential sum (denominator), and emits the per-beat
// numerator y = 2^-(runmax - x). Jobs cover ROWS rows and use a valid/ready
// input handshake.
// Optional build macro: SOFTMAX_DENOM_SAT_EN (denominator saturates at all-ones
// and raises the sticky o_sat flag instead of wrapping).
module softmax_online_p #(
   parameter int LANES  = 16,
   parameter int IN_W   = 40,
   parameter int FRAC_W = 10,
   parameter int Y_W    = 8,
   parameter int DEN_W  = 12,
   parameter int TILES  = 16,
   parameter int ROWS   = 64
) (
   input  logic                                   i_clk,
   input  logic                                   i_rst,
   input  logic                                   i_start,
   input  logic                                   i_valid,
   output logic                                   o_ready,
   input  logic [LANES*IN_W-1:0]                  i_data,
   output logic                                   o_y_valid,
   output logic [LANES*Y_W-1:0]                   o_y,
   output logic [LANES*(IN_W-FRAC_W)-1:0]         o_runmax,
   output logic [LANES*DEN_W-1:0]                 o_denom,
   output logic                                   o_denom_valid,
   output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] o_row_idx,
   output logic                                   o_done,
   output logic                                   o_sat
);

   localparam int INT_W  = IN_W - FRAC_W;
   localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int TILE_W = (TILES > 1) ? $clog2(TILES) : 1;
`ifdef SOFTMAX_DENOM_SAT_EN
   // One extra bit catches the carry out of every denominator add.
   localparam int SUM_W  = DEN_W + 1;
`else
   localparam int SUM_W  = DEN_W;
`endif

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ACC  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // 1.0 in both the numerator and the denominator formats (Y_W-1 fraction bits).
   localparam logic [Y_W-1:0]    Y_ONE     = {1'b1, {(Y_W-1){1'b0}}};
   localparam logic [DEN_W-1:0]  DEN_ONE   = DEN_W'(Y_ONE);
   localparam logic [IN_W:0]     HALF      = (IN_W+1)'(1) << (FRAC_W - 1);
   localparam logic [INT_W:0]    Y_LIM     = (INT_W+1)'(Y_W);
   localparam logic [INT_W:0]    DEN_LIM   = (INT_W+1)'(DEN_W);
   localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(TILES - 1);
   localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);

   logic [1:0]        state;
   logic [TILE_W-1:0] tile_cnt;
   logic [ROW_W-1:0]  row_cnt;
   logic              y_valid_q;
   logic              denom_valid_q;

   logic [Y_W-1:0]    y_q      [LANES];
   logic [INT_W-1:0]  runmax_q [LANES];
   logic [DEN_W-1:0]  denom_q  [LANES];

   logic [Y_W-1:0]    y_n      [LANES];
   logic [INT_W-1:0]  runmax_n [LANES];
   logic [DEN_W-1:0]  denom_n  [LANES];

`ifdef SOFTMAX_DENOM_SAT_EN
   logic              sat_q;
   logic [LANES-1:0]  ovf;
`endif

   logic accept;
   logic first_tile;
   logic last_tile;

   assign accept     = i_valid && (state == S_ACC);
   assign first_tile = (tile_cnt == '0);
   assign last_tile  = (tile_cnt == TILE_LAST);

   // Round a signed fixed-point score to INT_W signed integer bits, half away
   // from zero: round the magnitude, then restore the sign. The extra bit keeps
   // the magnitude of the most negative input representable.
   function automatic logic [INT_W-1:0] round_haz(input logic [IN_W-1:0] x);
      logic [IN_W:0] ext;
      logic [IN_W:0] mag;
      logic [IN_W:0] q;
      ext = {x[IN_W-1], x};
      mag = x[IN_W-1] ? -ext : ext;
      q   = (mag + HALF) >> FRAC_W;
      return x[IN_W-1] ? INT_W'(-q) : INT_W'(q);
   endfunction

   // Next-value datapath for every lane: rescale or accumulate the denominator.
   // NOTE: every variable written here gets a value before any branch, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      logic [INT_W-1:0]        r;
      logic signed [INT_W:0]   r_ext;
      logic signed [INT_W:0]   m_ext;
      logic [INT_W:0]          diff;
      logic [DEN_W-1:0]        shifted;
      logic [SUM_W-1:0]        sum;
      r       = '0;
      r_ext   = '0;
      m_ext   = '0;
      diff    = '0;
      shifted = '0;
      sum     = '0;
`ifdef SOFTMAX_DENOM_SAT_EN
      ovf     = '0;
`endif
      for (int k = 0; k < LANES; k++) begin
         r           = round_haz(i_data[k*IN_W +: IN_W]);
         r_ext       = {r[INT_W-1], r};
         m_ext       = {runmax_q[k][INT_W-1], runmax_q[k]};
         diff        = '0;
         shifted     = '0;
         y_n[k]      = Y_ONE;
         runmax_n[k] = runmax_q[k];
         if (first_tile) begin
            // Seed the row with its own first score rather than zero.
            runmax_n[k] = r;
            sum         = SUM_W'(DEN_ONE);
         end else if (r_ext > m_ext) begin
            // New maximum: rescale the old sum by 2^-d, then count this beat as 1.0.
            diff        = r_ext - m_ext;
            shifted     = (diff >= DEN_LIM) ? '0 : (denom_q[k] >> diff);
            sum         = SUM_W'(shifted) + SUM_W'(DEN_ONE);
            runmax_n[k] = r;
         end else begin
            // At or below the maximum: the numerator underflows to 0 past Y_W bits.
            diff   = m_ext - r_ext;
            y_n[k] = (diff >= Y_LIM) ? '0 : (Y_ONE >> diff);
            sum    = SUM_W'(denom_q[k]) + SUM_W'(y_n[k]);
         end
`ifdef SOFTMAX_DENOM_SAT_EN
         ovf[k]     = sum[DEN_W];
         denom_n[k] = sum[DEN_W] ? '1 : sum[DEN_W-1:0];
`else
         denom_n[k] = sum[DEN_W-1:0];
`endif
      end
   end

   // Control state, counters and per-lane statistics registers.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state         <= S_IDLE;
         tile_cnt      <= '0;
         row_cnt       <= '0;
         y_valid_q     <= 1'b0;
         denom_valid_q <= 1'b0;
         // NOTE: the statistics arrays are small register banks, not RAM, and are
         // cleared here so every output reads zero straight after reset.
         for (int k = 0; k < LANES; k++) begin
            y_q[k]      <= '0;
            runmax_q[k] <= '0;
            denom_q[k]  <= '0;
         end
`ifdef SOFTMAX_DENOM_SAT_EN
         sat_q         <= 1'b0;
`endif
      end else begin
         y_valid_q     <= accept;
         denom_valid_q <= accept && last_tile;

         case (state)
            S_IDLE:  if (i_start) state <= S_ACC;
            S_ACC:   if (accept && last_tile && (row_cnt == ROW_LAST)) state <= S_DONE;
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase

         if (accept) begin
            tile_cnt <= last_tile ? '0 : tile_cnt + TILE_W'(1);
            if (last_tile) begin
               row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + ROW_W'(1);
            end
            for (int k = 0; k < LANES; k++) begin
               y_q[k]      <= y_n[k];
               runmax_q[k] <= runmax_n[k];
               denom_q[k]  <= denom_n[k];
            end
         end

`ifdef SOFTMAX_DENOM_SAT_EN
         // Sticky until the next honoured start; a start cannot coincide with an accept.
         if ((state == S_IDLE) && i_start) begin
            sat_q <= 1'b0;
         end else if (accept && (|ovf)) begin
            sat_q <= 1'b1;
         end
`endif
      end
   end

   // Flatten the per-lane registers onto the lane-packed output buses.
   always_comb begin
      o_y      = '0;
      o_runmax = '0;
      o_denom  = '0;
      for (int k = 0; k < LANES; k++) begin
         o_y[k*Y_W +: Y_W]         = y_q[k];
         o_runmax[k*INT_W +: INT_W] = runmax_q[k];
         o_denom[k*DEN_W +: DEN_W] = denom_q[k];
      end
   end

   assign o_ready       = (state == S_ACC);
   assign o_done        = (state == S_DONE);
   assign o_y_valid     = y_valid_q;
   assign o_denom_valid = denom_valid_q;
   assign o_row_idx     = row_cnt;
`ifdef SOFTMAX_DENOM_SAT_EN
   assign o_sat         = sat_q;
`else
   assign o_sat         = 1'b0;
`endif

endmodule

// File: tb/tb_softmax_online_p.sv
// tb_softmax_online_p: self-checking bench for softmax_online_p.
// A behavioural model tracks job/row/tile position and per-lane max/sum with
// plain integer arithmetic; a negedge compare process checks every output each
// cycle. Directed rows pin the model with hand-computed literals; a second,
// narrow instance with long rows exercises denominator overflow.
module tb_softmax_online_p;

   localparam int LANES  = 16;
   localparam int IN_W   = 40;
   localparam int FRAC_W = 10;
   localparam int INT_W  = IN_W - FRAC_W;
   localparam int Y_W    = 8;
   localparam int DEN_W  = 12;
   localparam int TILES  = 16;
   localparam int ROWS   = 2;
   localparam int ONE    = 1 << (Y_W - 1);
   localparam int DMAX   = (1 << DEN_W) - 1;
   localparam int OV_LANES = 2;
   localparam int OV_TILES = 40;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                       rst;
   logic                       start;
   logic                       valid;
   logic                       ready;
   logic [LANES*IN_W-1:0]      data;
   logic                       y_valid;
   logic [LANES*Y_W-1:0]       y;
   logic [LANES*INT_W-1:0]     runmax;
   logic [LANES*DEN_W-1:0]     denom;
   logic                       denom_valid;
   logic [0:0]                 row_idx;
   logic                       done;
   logic                       sat;

   logic                       ov_start;
   logic                       ov_valid;
   logic                       ov_ready;
   logic [OV_LANES*IN_W-1:0]   ov_data;
   logic                       ov_y_valid;
   logic [OV_LANES*Y_W-1:0]    ov_y;
   logic [OV_LANES*INT_W-1:0]  ov_runmax;
   logic [OV_LANES*DEN_W-1:0]  ov_denom;
   logic                       ov_denom_valid;
   logic [0:0]                 ov_row_idx;
   logic                       ov_done;
   logic                       ov_sat;

   softmax_online_p #(.ROWS(ROWS)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid), .o_ready(ready),
      .i_data(data), .o_y_valid(y_valid), .o_y(y), .o_runmax(runmax), .o_denom(denom),
      .o_denom_valid(denom_valid), .o_row_idx(row_idx), .o_done(done), .o_sat(sat)
   );

   softmax_online_p #(.LANES(OV_LANES), .TILES(OV_TILES), .ROWS(1)) dut_ovf (
      .i_clk(clk), .i_rst(rst), .i_start(ov_start), .i_valid(ov_valid), .o_ready(ov_ready),
      .i_data(ov_data), .o_y_valid(ov_y_valid), .o_y(ov_y), .o_runmax(ov_runmax),
      .o_denom(ov_denom), .o_denom_valid(ov_denom_valid), .o_row_idx(ov_row_idx),
      .o_done(ov_done), .o_sat(ov_sat)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         if (n_errors <= 40) $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int     m_phase;   // 0 idle, 1 accumulating, 2 job finished
   int     m_tile;
   int     m_row;
   bit     m_sat;
   bit     e_yv;
   bit     e_dv;
   longint m_rm  [LANES];
   int     m_den [LANES];
   int     m_y   [LANES];

   function automatic longint rnd(input longint x);
      longint half = longint'(1) << (FRAC_W - 1);
      longint one  = longint'(1) << FRAC_W;
      return (x >= 0) ? (x + half) / one : -((-x + half) / one);
   endfunction

   always @(posedge clk) begin : model
      bit acc;
      if (rst) begin
         m_phase = 0; m_tile = 0; m_row = 0; m_sat = 0; e_yv = 0; e_dv = 0;
         for (int k = 0; k < LANES; k++) begin
            m_rm[k] = 0; m_den[k] = 0; m_y[k] = 0;
         end
      end else begin
         acc  = (m_phase == 1) && valid;
         e_yv = acc;
         e_dv = 0;
         if (m_phase == 0) begin
            if (start) begin
               m_phase = 1;
               m_sat   = 0;
            end
         end else if (m_phase == 2) begin
            m_phase = 0;
         end else if (acc) begin
            for (int k = 0; k < LANES; k++) begin
               logic signed [IN_W-1:0] xs;
               longint r;
               longint d;
               xs = data[k*IN_W +: IN_W];
               r  = rnd(longint'(xs));
               if (m_tile == 0) begin
                  m_rm[k] = r; m_y[k] = ONE; m_den[k] = ONE;
               end else if (r > m_rm[k]) begin
                  d        = r - m_rm[k];
                  m_den[k] = ((d >= DEN_W) ? 0 : (m_den[k] >> d)) + ONE;
                  m_y[k]   = ONE;
                  m_rm[k]  = r;
               end else begin
                  d        = m_rm[k] - r;
                  m_y[k]   = (d >= Y_W) ? 0 : (ONE >> d);
                  m_den[k] = m_den[k] + m_y[k];
               end
`ifdef SOFTMAX_DENOM_SAT_EN
               if (m_den[k] > DMAX) begin
                  m_den[k] = DMAX;
                  m_sat    = 1;
               end
`else
               m_den[k] = m_den[k] % (DMAX + 1);
`endif
            end
            m_tile++;
            if (m_tile == TILES) begin
               m_tile = 0;
               e_dv   = 1;
               m_row++;
               if (m_row == ROWS) begin
                  m_row   = 0;
                  m_phase = 2;
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   bit cmp_en = 0;

   always @(negedge clk) begin
      if (cmp_en) begin
         logic [LANES*Y_W-1:0]   ey;
         logic [LANES*INT_W-1:0] erm;
         logic [LANES*DEN_W-1:0] eden;
         for (int k = 0; k < LANES; k++) begin
            ey[k*Y_W +: Y_W]       = m_y[k][Y_W-1:0];
            erm[k*INT_W +: INT_W]  = m_rm[k][INT_W-1:0];
            eden[k*DEN_W +: DEN_W] = m_den[k][DEN_W-1:0];
         end
         check("ready",       ready,       m_phase == 1);
         check("done",        done,        m_phase == 2);
         check("y_valid",     y_valid,     e_yv);
         check("denom_valid", denom_valid, e_dv);
         check("row_idx",     row_idx,     512'(m_row));
         check("sat",         sat,         m_sat);
         check("y",           y,           ey);
         check("runmax",      runmax,      erm);
         check("denom",       denom,       eden);
      end
   end

   // Pulse counters for the back-pressure job.
   bit cnt_en = 0;
   int n_yv   = 0;
   int n_done = 0;

   always @(negedge clk) begin
      if (cnt_en) begin
         if (y_valid) n_yv++;
         if (done)    n_done++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic start_job();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   // Present one beat, optionally with random idle cycles; returns at the
   // negedge whose following posedge accepts it.
   task automatic send_beat(input logic [LANES*IN_W-1:0] d, input bit stall);
      bit acc = 1'b0;
      int n   = 0;
      while (!acc && n < 200) begin
         @(negedge clk);
         if (stall && ($urandom_range(0, 1) == 0)) begin
            valid = 1'b0;
         end else begin
            valid = 1'b1;
            data  = d;
         end
         acc = valid && ready;
         n++;
      end
      check("beat_accept", acc, 1'b1);
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      int n    = 0;
      while (!seen && n < 100) begin
         @(negedge clk);
         valid = 1'b0;
         seen  = done;
         n++;
      end
      check("done_seen", seen, 1'b1);
   endtask

   function automatic logic [LANES*IN_W-1:0] rand_row();
      logic [LANES*IN_W-1:0] v;
      longint x;
      for (int k = 0; k < LANES; k++) begin
         x = longint'($urandom_range(0, 40960)) - 64'sd20480;
         v[k*IN_W +: IN_W] = x[IN_W-1:0];
      end
      return v;
   endfunction

   function automatic logic [LANES*IN_W-1:0] lane0_row(input longint v0);
      logic [LANES*IN_W-1:0] v = '0;
      v[IN_W-1:0] = v0[IN_W-1:0];
      return v;
   endfunction

   // Lane-0 directed row: value, then expected y / denom / runmax after the beat.
   longint d_in  [8] = '{0, 1024, 2048, -6144, -1024, 512, 511, -512};
   int     d_y   [8] = '{8'h80, 8'h80, 8'h80, 8'h00, 8'h10, 8'h40, 8'h20, 8'h10};
   int     d_den [8] = '{128, 192, 224, 224, 240, 304, 336, 352};
   int     d_rm  [8] = '{0, 1, 2, 2, 2, 2, 2, 2};

   initial begin
      rst = 1'b1; start = 1'b0; valid = 1'b0; data = '0;
      ov_start = 1'b0; ov_valid = 1'b0; ov_data = '0;
      repeat (3) @(negedge clk);

      // Reset state.
      check("rst_y",      y,      '0);
      check("rst_runmax", runmax, '0);
      check("rst_denom",  denom,  '0);
      check("rst_flags",  {ready, y_valid, denom_valid, done, sat, row_idx}, '0);
      rst    = 1'b0;
      cmp_en = 1'b1;

      // Job 1, row 0: uniform zero scores.
      start_job();
      for (int i = 0; i < TILES; i++) send_beat('0, 1'b0);
      @(negedge clk); valid = 1'b0;
      check("uni_y",     y,      {LANES{8'h80}});
      check("uni_denom", denom,  {LANES{12'h800}});
      check("uni_max",   runmax, '0);
      check("uni_dv",    denom_valid, 1'b1);
      check("uni_row",   row_idx, 1'b1);

      // Job 1, row 1: rising max, underflow and rounding on lane 0.
      for (int i = 0; i < 8; i++) begin
         send_beat(lane0_row(d_in[i]), 1'b0);
         @(negedge clk); valid = 1'b0;
         check("dir_y",   y[Y_W-1:0],       d_y[i][Y_W-1:0]);
         check("dir_den", denom[DEN_W-1:0], d_den[i][DEN_W-1:0]);
         check("dir_max", runmax[INT_W-1:0], d_rm[i][INT_W-1:0]);
      end
      for (int i = 8; i < TILES; i++) send_beat('0, 1'b0);
      @(negedge clk); valid = 1'b0;
      check("row1_den0", denom[DEN_W-1:0],       12'd608);
      check("row1_den1", denom[2*DEN_W-1:DEN_W], 12'h800);
      check("row1_end",  {done, denom_valid, ready, row_idx}, 4'b1100);
      @(negedge clk);
      check("job1_idle", {done, ready}, 2'b00);

      // Job 2: random data with random back-pressure.
      cnt_en = 1'b1;
      n_yv   = 0;
      n_done = 0;
      start_job();
      for (int i = 0; i < ROWS*TILES; i++) send_beat(rand_row(), 1'b1);
      wait_done();
      repeat (3) @(negedge clk);
      cnt_en = 1'b0;
      check("bp_yv_count",   32'(n_yv),   32'd32);
      check("bp_done_count", 32'(n_done), 32'd1);
      check("bp_ready",      ready,       1'b0);

      // Job 3: reset after 5 accepts, then a fresh continuous job.
      start_job();
      for (int i = 0; i < 5; i++) send_beat(rand_row(), 1'b0);
      @(negedge clk); valid = 1'b0; rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      check("mid_rst_y",     y,      '0);
      check("mid_rst_max",   runmax, '0);
      check("mid_rst_den",   denom,  '0);
      check("mid_rst_flags", {ready, y_valid, denom_valid, done, sat, row_idx}, '0);
      start_job();
      check("restart", {ready, row_idx}, 2'b10);
      for (int i = 0; i < ROWS*TILES; i++) send_beat(rand_row(), 1'b0);
      wait_done();

      // Overflow: 40 zero beats in one row.
      @(negedge clk); ov_start = 1'b1;
      @(negedge clk); ov_start = 1'b0;
      check("ov_ready", ov_ready, 1'b1);
      ov_valid = 1'b1;
      repeat (OV_TILES) @(negedge clk);
      ov_valid = 1'b0;
      check("ov_y",     ov_y,      {OV_LANES{8'h80}});
      check("ov_max",   ov_runmax, '0);
      check("ov_flags", {ov_y_valid, ov_denom_valid, ov_done, ov_row_idx}, 4'b1110);
`ifdef SOFTMAX_DENOM_SAT_EN
      check("ov_denom", ov_denom, {OV_LANES{12'hFFF}});
      check("ov_sat",   ov_sat,   1'b1);
`else
      check("ov_denom", ov_denom, {OV_LANES{12'h400}});
      check("ov_sat",   ov_sat,   1'b0);
`endif

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
